// File: rtl/alu_seq_exec.sv
// ============================================================================
// alu_seq_exec
// ----------------------------------------------------------------------------
// Sequential execute-stage ALU. Logic, add/sub and set-less-than operations
// finish one cycle after the request is accepted. Left shifts run through a
// serial shifter that moves one bit per cycle, so a shift by N finishes N+1
// cycles after acceptance. A start/busy/done handshake lets the datapath
// controller stall until the result is valid.
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous, active-high reset
//   start     request strobe, honoured only while busy=0
//   ALUctr    4-bit operation code, captured with start
//   SllFlag   shift request, captured with start
//   busA      operand A, captured with start
//   busB      operand B / value to shift, captured with start
//   shamt     shift amount, captured with start
//   result    registered result, held until the next completion
//   zero      registered, 1 when result is zero
//   overflow  registered signed overflow for add/sub codes, else 0
//   busy      high from the cycle after acceptance through the done cycle
//   done      one-cycle completion pulse
// ============================================================================
module alu_seq_exec #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       ALUctr,
    input  logic             SllFlag,
    input  logic [WIDTH-1:0] busA,
    input  logic [WIDTH-1:0] busB,
    input  logic [SHW-1:0]   shamt,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b0101;
    localparam logic [3:0] OP_SLL  = 4'b1000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EXEC  = 2'd1,
        S_SHIFT = 2'd2
    } state_t;

    state_t           state_reg,  state_next;
    logic [WIDTH-1:0] a_reg,      a_next;
    // b_reg doubles as the shift register while in S_SHIFT.
    logic [WIDTH-1:0] b_reg,      b_next;
    logic [3:0]       code_reg,   code_next;
    logic [SHW-1:0]   cnt_reg,    cnt_next;
    logic [WIDTH-1:0] result_reg, result_next;
    logic             zero_reg,   zero_next;
    logic             ovf_reg,    ovf_next;
    logic             busy_reg,   busy_next;
    logic             done_reg,   done_next;

    // ------------------------------------------------------------------------
    // Single-cycle ALU on the captured operands
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] and_vec;
    logic [WIDTH-1:0] or_vec;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             lt_signed;
    logic             lt_unsigned;
    logic             ovf_add;
    logic             ovf_sub;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bitwise
            assign and_vec[gi] = a_reg[gi] & b_reg[gi];
            assign or_vec[gi]  = a_reg[gi] | b_reg[gi];
        end
    endgenerate

    assign sum         = a_reg + b_reg;
    assign diff        = a_reg - b_reg;
    assign lt_signed   = $signed(a_reg) < $signed(b_reg);
    assign lt_unsigned = a_reg < b_reg;

    // Overflow when both effective operands share a sign and the result's
    // sign differs; subtraction flips the sign of B.
    assign ovf_add = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                     (sum[WIDTH-1]   != a_reg[WIDTH-1]);
    assign ovf_sub = (a_reg[WIDTH-1] != b_reg[WIDTH-1]) &&
                     (diff[WIDTH-1]  != a_reg[WIDTH-1]);

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (code_reg)
            OP_AND:  alu_res = and_vec;
            OP_OR:   alu_res = or_vec;
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = ovf_add;
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = ovf_sub;
            end
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, lt_signed};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, lt_unsigned};
            default: begin
                alu_res = '0;
                alu_ovf = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_next  = state_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        code_next   = code_reg;
        cnt_next    = cnt_reg;
        result_next = result_reg;
        zero_next   = zero_reg;
        ovf_next    = ovf_reg;
        busy_next   = busy_reg;
        done_next   = 1'b0;

        case (state_reg)
            S_IDLE: begin
                // In IDLE busy_reg is only high during the done cycle, which
                // is exactly when a new start must be ignored.
                busy_next = 1'b0;
                if (start && !busy_reg) begin
                    a_next    = busA;
                    b_next    = busB;
                    code_next = ALUctr;
                    cnt_next  = shamt;
                    busy_next = 1'b1;
                    if (SllFlag || (ALUctr == OP_SLL)) begin
                        state_next = S_SHIFT;
                    end else begin
                        state_next = S_EXEC;
                    end
                end
            end

            S_EXEC: begin
                result_next = alu_res;
                zero_next   = (alu_res == '0);
                ovf_next    = alu_ovf;
                done_next   = 1'b1;
                state_next  = S_IDLE;
            end

            S_SHIFT: begin
                if (cnt_reg != '0) begin
                    b_next   = b_reg << 1;
                    cnt_next = cnt_reg - SHW'(1);
                end else begin
                    result_next = b_reg;
                    zero_next   = (b_reg == '0);
                    ovf_next    = 1'b0;
                    done_next   = 1'b1;
                    state_next  = S_IDLE;
                end
            end

            default: begin
                state_next = S_IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            code_reg   <= '0;
            cnt_reg    <= '0;
            result_reg <= '0;
            zero_reg   <= 1'b1;
            ovf_reg    <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            code_reg   <= code_next;
            cnt_reg    <= cnt_next;
            result_reg <= result_next;
            zero_reg   <= zero_next;
            ovf_reg    <= ovf_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
        end
    end

    assign result   = result_reg;
    assign zero     = zero_reg;
    assign overflow = ovf_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;

endmodule

// File: tb/tb_alu_seq_exec.sv
// ============================================================================
// tb_alu_seq_exec
// ----------------------------------------------------------------------------
// Scoreboarded bench for alu_seq_exec. Each issued request pushes its
// expected result, overflow and completion cycle; a monitor on the falling
// edge pops and compares whenever done is high. Any done with an empty
// scoreboard is an error.
// ============================================================================
module tb_alu_seq_exec;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  ALUctr;
    logic        SllFlag;
    logic [31:0] busA;
    logic [31:0] busB;
    logic [4:0]  shamt;
    logic [31:0] result;
    logic        zero;
    logic        overflow;
    logic        busy;
    logic        done;

    alu_seq_exec #(.WIDTH(32), .SHW(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .ALUctr   (ALUctr),
        .SllFlag  (SllFlag),
        .busA     (busA),
        .busB     (busB),
        .shamt    (shamt),
        .result   (result),
        .zero     (zero),
        .overflow (overflow),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        int          due;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: straight arithmetic on the operation's definition.
    function automatic void model(input logic [3:0] code, input logic flag,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input int sh, output logic [31:0] r,
                                  output logic o);
        longint sa, sbv, s;
        longint maxv, minv;
        maxv = 64'sh7FFFFFFF;
        minv = -maxv - 1;
        sa   = longint'($signed(a));
        sbv  = longint'($signed(b));
        r = 32'h0;
        o = 1'b0;
        if (flag || code == 4'b1000) begin
            r = b << sh;
        end else begin
            case (code)
                4'b0000: r = a & b;
                4'b0001: r = a | b;
                4'b0010: begin
                    s = sa + sbv;
                    r = a + b;
                    o = (s > maxv) || (s < minv);
                end
                4'b0110: begin
                    s = sa - sbv;
                    r = a - b;
                    o = (s > maxv) || (s < minv);
                end
                4'b0111: r = (sa < sbv) ? 32'd1 : 32'd0;
                4'b0101: r = (a < b) ? 32'd1 : 32'd0;
                default: r = 32'h0;
            endcase
        end
    endfunction

    // Monitor: compare every completion against the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: done=1 with no request pending, result=0x%08h (cycle %0d)",
                         result, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("txn done: result=0x%08h zero=%0b ovf=%0b cycle=%0d", result, zero, overflow, cyc);
                check("result",   result,          e.res);
                check("zero",     {31'b0, zero},   {31'b0, (e.res == 32'h0)});
                check("overflow", {31'b0, overflow}, {31'b0, e.ovf});
                check("latency",  cyc,             e.due);
            end
        end
    end

    // Called just after a rising edge; start is sampled at the next edge.
    task automatic issue(input logic [3:0] code, input logic flag,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input bit push);
        exp_t e;
        logic [31:0] r;
        logic o;
        int lat;
        model(code, flag, a, b, int'(sh), r, o);
        lat = (flag || code == 4'b1000) ? 1 + int'(sh) : 1;
        if (push) begin
            e.res = r;
            e.ovf = o;
            e.due = cyc + 1 + lat;
            sb.push_back(e);
        end
        ALUctr  = code;
        SllFlag = flag;
        busA    = a;
        busB    = b;
        shamt   = sh;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        // Scramble the inputs: the operation in flight must not see them.
        ALUctr  = 4'($urandom);
        SllFlag = 1'($urandom);
        busA    = $urandom;
        busB    = $urandom;
        shamt   = 5'($urandom);
    endtask

    // Wait (bounded) for done; optionally fire a stray start in the done cycle.
    // Returns just after the edge that clears done.
    task automatic wait_done(input bit poke_in_done);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: no done within 40 cycles (cycle %0d)", cyc);
            if (sb.size() != 0) void'(sb.pop_front());
        end
        if (poke_in_done) begin
            ALUctr  = 4'b0001;
            SllFlag = 1'b0;
            busA    = 32'hFFFF_FFFF;
            busB    = 32'h0;
            start   = 1'b1;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run(input logic [3:0] code, input logic flag,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh);
        issue(code, flag, a, b, sh, 1'b1);
        wait_done(1'b0);
    endtask

    logic [3:0] codes [10];

    initial begin
        codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111,
                  4'b0101, 4'b1000, 4'b0011, 4'b1111, 4'b0100};
        rst     = 1'b1;
        start   = 1'b0;
        ALUctr  = 4'b0;
        SllFlag = 1'b0;
        busA    = 32'h0;
        busB    = 32'h0;
        shamt   = 5'd0;

        // Reset state, then 10 idle cycles.
        repeat (3) @(posedge clk);
        #1;
        check("rst_result", result, 32'h0);
        check("rst_zero",   {31'b0, zero}, 32'd1);
        check("rst_busy",   {31'b0, busy}, 32'd0);
        check("rst_done",   {31'b0, done}, 32'd0);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("idle_result",   result, 32'h0);
        check("idle_zero",     {31'b0, zero}, 32'd1);
        check("idle_overflow", {31'b0, overflow}, 32'd0);
        check("idle_busy",     {31'b0, busy}, 32'd0);

        // Directed cases.
        run(4'b0010, 1'b0, 32'h7FFF_FFFF, 32'h1,          5'd0);
        run(4'b0110, 1'b0, 32'h1234,      32'h1234,       5'd0);
        run(4'b0111, 1'b0, 32'hFFFF_FFFF, 32'h1,          5'd0);
        run(4'b0101, 1'b0, 32'hFFFF_FFFF, 32'h1,          5'd0);
        run(4'b0110, 1'b0, 32'h8000_0000, 32'h1,          5'd0);
        run(4'b0000, 1'b1, 32'hDEAD_BEEF, 32'h0000_0001,  5'd31);
        run(4'b0010, 1'b1, 32'hDEAD_BEEF, 32'h1357_9BDF,  5'd0);
        run(4'b0000, 1'b1, 32'h0,         32'hF000_000F,  5'd4);
        run(4'b1000, 1'b0, 32'h0,         32'h0000_00A5,  5'd3);
        run(4'b1010, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  5'd0);

        // Starts during busy and in the done cycle must be ignored.
        issue(4'b1000, 1'b1, 32'h0, 32'h0000_0C3F, 5'd8, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        ALUctr  = 4'b0001;
        SllFlag = 1'b0;
        busA    = 32'h5555_5555;
        busB    = 32'hAAAA_AAAA;
        start   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(1'b1);
        repeat (12) @(posedge clk);
        #1;
        check("busy_after_ignored_starts", {31'b0, busy}, 32'd0);
        check("result_held", result, 32'h0000_0C3F << 8);

        // Reset mid-shift: no completion, outputs back to reset values.
        issue(4'b0000, 1'b1, 32'h0, 32'h0000_0003, 5'd20, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        check("midrst_result", result, 32'h0);
        check("midrst_zero",   {31'b0, zero}, 32'd1);
        check("midrst_busy",   {31'b0, busy}, 32'd0);
        check("midrst_done",   {31'b0, done}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        check("post_rst_busy", {31'b0, busy}, 32'd0);
        run(4'b0010, 1'b0, 32'd100, 32'hFFFF_FFFF, 5'd0);

        // Randomized traffic.
        for (int n = 0; n < 60; n++) begin
            logic [3:0]  c;
            logic        f;
            logic [31:0] a;
            logic [31:0] b;
            c = codes[$urandom_range(0, 9)];
            f = ($urandom_range(0, 5) == 0);
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            if ($urandom_range(0, 4) == 0) a = {1'b0, 31'h7FFF_FFFF} ^ {31'b0, 1'($urandom)};
            run(c, f, a, b, 5'($urandom));
        end

        repeat (3) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d expected completions never seen, expected 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_seq_exec.md
# alu_seq_exec

Sequential execute-stage ALU that consumes the 4-bit ALU control code and shift flag produced by the ALU control decoder, together with the register-file operands. Single-cycle arithmetic and logic operations complete in one clock. Left shifts run through a serial 1-bit-per-cycle shifter, which saves a 32-bit barrel shifter. A start/busy/done handshake lets the datapath controller stall until the result is valid.

## Interface
- WIDTH, 32, operand/result width (only 32 is verified)
- SHW, 5, shift-amount width; must equal log2(WIDTH)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only when busy=0
- ALUctr  in  4  operation code from ALU control decoder, sampled with start
- SllFlag  in  1  shift request from ALU control decoder, sampled with start
- busA  in  WIDTH  operand A (rs)
- busB  in  WIDTH  operand B (rt or sign-extended immediate), sampled with start
- shamt  in  SHW  shift amount, sampled with start
- result  out  WIDTH  registered result; holds its value until the next completion
- zero  out  1  registered; 1 when result==0
- overflow  out  1  registered signed overflow, valid for add/sub codes only, else 0
- busy  out  1  1 from the cycle after an accepted start until the done cycle, inclusive
- done  out  1  one-cycle pulse; result, zero and overflow are valid from this cycle on

## Operation
- ALUctr codes:
  - 0000: A&B
  - 0001: A|B
  - 0010: A+B
  - 0110: A-B
  - 0111: signed A<B → 1, else 0
  - 0101: unsigned A<B → 1, else 0
  - 1000: sll
  - Any other code: result 0, overflow 0; the operation still completes normally.
- Shift selection:
  - SllFlag=1 selects the shift path regardless of ALUctr.
  - ALUctr=1000 with SllFlag=0 also selects the shift path.
- Shift semantics: result = busB << shamt, with zero fill. The shifted operand is busB; busA is ignored.
- Add/sub arithmetic:
  - Computed modulo 2^WIDTH.
  - overflow = (signA==signB') && (signR!=signA), where B' = B for add and ~B for sub.
- Operand capture: on an accepted start, operands, code, flag and shamt are latched. Input changes after that cycle do not affect the operation in flight.
- FSM states:
  - IDLE: busy=0. On start, go to EXEC (non-shift) or SHIFT (shift).
  - EXEC: compute and register the outputs, pulse done, return to IDLE.
  - SHIFT: a shift register is loaded with busB and a down-counter with shamt.
    - Each cycle with counter≠0: shift left by 1 and decrement.
    - When counter==0: register the outputs, pulse done, return to IDLE.
- start asserted while busy=1 is ignored; it is neither queued nor does it disturb the operation in flight.
- start asserted in the done cycle is ignored. A new request is accepted no earlier than the cycle after done.

## Timing
- Reset values (asynchronous assert):
  - result=0, zero=1, overflow=0, busy=0, done=0
  - FSM in IDLE, shift counter cleared
- Reset deassertion is synchronous to clk. The first start is accepted on the first rising edge after rst falls.
- Non-shift latency: start sampled at edge N → done=1 and outputs valid after edge N+1.
- Shift latency: start at edge N → done after edge N+1+shamt.
  - shamt=0 → done after N+1, result=busB.
  - shamt=31 → done after N+32.
- busy rises after edge N and falls after the edge that clears done. busy and done are high together in the done cycle.
- Reset asserted mid-operation: the operation is aborted, outputs return to their reset values, and no done pulse is produced.
- Outputs change only in the done cycle or on reset.

## Test plan
- Reset with no start:
  - Stimulus: hold rst=1, then release; apply no start.
  - Required response: result=0, zero=1, busy=0, done=0. The outputs hold across 10 idle cycles.
- Add with overflow:
  - Stimulus: ALUctr=0010, A=0x7FFFFFFF, B=1, start.
  - Required response: done one cycle later, result=0x80000000, overflow=1, zero=0.
- Sub to zero, then slt:
  - Stimulus: ALUctr=0110, A=B=0x1234.
  - Required response: result=0, zero=1, overflow=0.
  - Then stimulus: ALUctr=0111, A=0xFFFFFFFF, B=1.
  - Required response: result=1.
  - Then ALUctr=0101 with the same operands.
  - Required response: result=0.
- Shift latency and boundaries:
  - SllFlag=1, B=0x00000001, shamt=31 → done exactly 32 cycles after start, result=0x80000000.
  - shamt=0 → done after 1 cycle, result=B.
  - shamt=4, B=0xF000000F → result=0x000000F0.
- Start while busy:
  - Stimulus: sll with shamt=8; assert start with ALUctr=0001 during busy and again in the done cycle.
  - Required response: both starts are ignored, exactly one done pulse, result is the shift value.
- Reset mid-shift:
  - Stimulus: sll with shamt=20; assert rst at cycle 5.
  - Required response: result=0, busy=0, no done pulse.
  - Then: a new add request after reset completes normally in 1 cycle.
